// File: rtl/ripple_count_sampler.sv
`default_nettype none
// ============================================================================
// Module      : ripple_count_sampler
// Description : Brings the q bus of a 4-bit ripple down counter into the clk
//               domain and accepts a value only once it has been steady for
//               a number of samples. Counts underflow wraps (0 -> all-ones)
//               and returns a count/wrap snapshot over a valid/ready handshake.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               cnt_in        - ripple counter q bus (asynchronous to clk)
//               sample_req    - snapshot request, taken only while idle
//               busy          - request in progress (WAIT or HOLD)
//               out_valid     - snapshot presented (HOLD)
//               out_ready     - consumer accepts the snapshot
//               out_count     - captured count
//               out_wraps     - captured wrap count
//               out_err       - snapshot was forced by the wait timeout
//               wrap_pulse    - one-cycle pulse per detected underflow wrap
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_count_sampler #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_W        = 8,
  parameter int TIMEOUT       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              sample_req,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_count,
  output logic [WRAP_W-1:0] out_wraps,
  output logic              out_err,
  output logic              wrap_pulse
);

  localparam int RUN_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [RUN_W-1:0] c_RUN_MAX  = RUN_W'(STABLE_CYCLES);
  localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Synchroniser and stability tracking
  logic [WIDTH-1:0]  r_s1;
  logic [WIDTH-1:0]  r_s2;
  logic [WIDTH-1:0]  r_s2_d;
  logic [RUN_W-1:0]  r_run;
  logic [WIDTH-1:0]  r_stable_val;
  logic              r_seen;
  logic [WRAP_W-1:0] r_wrap_cnt;
  logic              r_wrap_pulse;

  // Handshake FSM
  state_t            r_state;
  logic [TMR_W-1:0]  r_timer;
  logic [WIDTH-1:0]  r_out_count;
  logic [WRAP_W-1:0] r_out_wraps;
  logic              r_out_err;

  logic              w_eq;
  logic              w_stable;
  logic              w_wrap;
  logic [WRAP_W-1:0] w_wrap_next;

  assign w_eq = (r_s2 == r_s2_d);

  // The run length alone lags the newest sample by one edge, so a single
  // mid-ripple code would be trusted on the edge it first appears in s2.
  // Also requiring the current pair to match keeps one-sample glitches out.
  assign w_stable = (r_run >= c_RUN_MAX) && w_eq;

  assign w_wrap = w_stable && r_seen && (r_stable_val == '0) && (r_s2 == c_ALL_ONES);

  // A capture on the same edge as a wrap reports the incremented count.
  assign w_wrap_next = w_wrap ? (r_wrap_cnt + 1'b1) : r_wrap_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1         <= '0;
      r_s2         <= '0;
      r_s2_d       <= '0;
      r_run        <= '0;
      r_stable_val <= '0;
      r_seen       <= 1'b0;
      r_wrap_cnt   <= '0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_s1   <= cnt_in;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;

      if (!w_eq) begin
        r_run <= '0;
      end else if (r_run != c_RUN_MAX) begin
        r_run <= r_run + 1'b1;
      end

      if (w_stable) begin
        r_stable_val <= r_s2;
        r_seen       <= 1'b1;
      end

      r_wrap_cnt   <= w_wrap_next;
      r_wrap_pulse <= w_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_out_count <= '0;
      r_out_wraps <= '0;
      r_out_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sample_req) begin
            r_state <= S_WAIT;
            r_timer <= '0;
          end
        end
        S_WAIT: begin
          if (w_stable) begin
            r_out_count <= r_s2;
            r_out_wraps <= w_wrap_next;
            r_out_err   <= 1'b0;
            r_state     <= S_HOLD;
          end else if (r_timer == c_TMR_LAST) begin
            r_out_count <= r_s2;
            r_out_wraps <= w_wrap_next;
            r_out_err   <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign out_valid  = (r_state == S_HOLD);
  assign out_count  = r_out_count;
  assign out_wraps  = r_out_wraps;
  assign out_err    = r_out_err;
  assign wrap_pulse = r_wrap_pulse;

endmodule
`default_nettype wire

// File: tb/tb_ripple_count_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ripple_count_sampler
// Description : Directed self-checking bench for ripple_count_sampler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_count_sampler;

  logic       clk;
  logic       rst;
  logic [3:0] cnt_in;
  logic       sample_req;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_count;
  logic [7:0] out_wraps;
  logic       out_err;
  logic       wrap_pulse;

  int total;
  int bad;
  int pulse_cnt;

  ripple_count_sampler dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .sample_req (sample_req),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
    .out_wraps  (out_wraps),
    .out_err    (out_err),
    .wrap_pulse (wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wrap_pulse === 1'b1) pulse_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_req = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic hold_value(input logic [3:0] v, input int n);
    cnt_in = v;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Requests a snapshot and waits (bounded) for out_valid; edges counts the
  // clock edges from the request edge until out_valid is seen high.
  task automatic get_snapshot(output int edges);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    edges = 1;
    while (out_valid !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic release_snapshot();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    cnt_in = 4'h9;
    do_reset();
    total++;
    if ({busy, out_valid, out_err, wrap_pulse} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got busy/valid/err/pulse=%b want 0000",
               {busy, out_valid, out_err, wrap_pulse});
    end
    total++;
    if (out_count !== 4'h0 || out_wraps !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: got count=%h wraps=%h want 0/00", out_count, out_wraps);
    end
  endtask

  task automatic test_basic_snapshot();
    int ok;
    cnt_in = 4'h7;
    do_reset();
    hold_value(4'h7, 6);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_edge: got busy=%b valid=%b want 1/0", busy, out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_count !== 4'h7 || out_err !== 1'b0 || out_wraps !== 8'h00) begin
      bad++;
      $display("FAIL snap_7: got valid=%b count=%h err=%b wraps=%h want 1/7/0/00",
               out_valid, out_count, out_err, out_wraps);
    end
    // Input moves and a new request arrives while held: nothing may change.
    cnt_in = 4'h8;
    sample_req = 1'b1;
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_count !== 4'h7 || out_err !== 1'b0 || busy !== 1'b1) ok = 0;
    end
    sample_req = 1'b0;
    total++;
    if (ok != 1) begin
      bad++;
      $display("FAIL hold_stall: got valid=%b count=%h want 1/7 held", out_valid, out_count);
    end
    release_snapshot();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_count !== 4'h7) begin
      bad++;
      $display("FAIL release: got valid=%b busy=%b count=%h want 0/0/7", out_valid, busy, out_count);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    hold_value(4'h8, 7);
    get_snapshot(edges);
    total++;
    if (edges != 2 || out_count !== 4'h8) begin
      bad++;
      $display("FAIL b2b_snap: got edges=%0d count=%h want 2/8", edges, out_count);
    end
    // Accept and request in the same cycle: the request is dropped.
    out_ready = 1'b1;
    sample_req = 1'b1;
    tick();
    out_ready = 1'b0;
    sample_req = 1'b0;
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL req_with_ready: got busy=%b valid=%b want 0/0", busy, out_valid);
    end
    // out_ready while idle is ignored.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (busy !== 1'b0 || out_count !== 4'h8) begin
      bad++;
      $display("FAIL idle_ready: got busy=%b count=%h want 0/8", busy, out_count);
    end
  endtask

  task automatic test_wrap();
    int edges;
    int p0;
    cnt_in = 4'h3;
    do_reset();
    p0 = pulse_cnt;
    hold_value(4'h3, 8);
    hold_value(4'h2, 8);
    hold_value(4'h1, 8);
    hold_value(4'h0, 8);
    hold_value(4'hF, 8);
    total++;
    if (pulse_cnt - p0 != 1) begin
      bad++;
      $display("FAIL wrap_pulses: got %0d want 1", pulse_cnt - p0);
    end
    get_snapshot(edges);
    total++;
    if (out_valid !== 1'b1 || out_wraps !== 8'h01 || out_count !== 4'hF || out_err !== 1'b0) begin
      bad++;
      $display("FAIL wrap_snap: got valid=%b wraps=%h count=%h err=%b want 1/01/F/0",
               out_valid, out_wraps, out_count, out_err);
    end
    release_snapshot();
  endtask

  task automatic test_timeout();
    int edges;
    cnt_in = 4'h5;
    do_reset();
    sample_req = 1'b1;
    cnt_in = 4'hA;
    tick();
    sample_req = 1'b0;
    edges = 1;
    while (out_valid !== 1'b1 && edges < 40) begin
      cnt_in = ~cnt_in;
      tick();
      edges++;
    end
    total++;
    if (edges != 17) begin
      bad++;
      $display("FAIL timeout_latency: got %0d edges want 17", edges);
    end
    total++;
    if (out_valid !== 1'b1 || out_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_err: got valid=%b err=%b want 1/1", out_valid, out_err);
    end
    release_snapshot();
    hold_value(4'h3, 7);
    get_snapshot(edges);
    total++;
    if (edges != 2 || out_err !== 1'b0 || out_count !== 4'h3) begin
      bad++;
      $display("FAIL err_clear: got edges=%0d err=%b count=%h want 2/0/3", edges, out_err, out_count);
    end
    release_snapshot();
  endtask

  task automatic test_glitch();
    int edges;
    int p0;
    cnt_in = 4'h0;
    do_reset();
    p0 = pulse_cnt;
    hold_value(4'h0, 8);
    hold_value(4'hF, 1);
    hold_value(4'h0, 8);
    total++;
    if (pulse_cnt != p0) begin
      bad++;
      $display("FAIL glitch_pulse: got %0d pulses want 0", pulse_cnt - p0);
    end
    get_snapshot(edges);
    total++;
    if (out_wraps !== 8'h00 || out_count !== 4'h0 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL glitch_snap: got wraps=%h count=%h err=%b want 00/0/0", out_wraps, out_count, out_err);
    end
    release_snapshot();
  endtask

  task automatic test_reset_hold_rollover();
    int edges;
    int p0;
    cnt_in = 4'h6;
    do_reset();
    hold_value(4'h6, 7);
    get_snapshot(edges);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_count !== 4'h0) begin
      bad++;
      $display("FAIL rst_in_hold: got valid=%b busy=%b count=%h want 0/0/0", out_valid, busy, out_count);
    end
    p0 = pulse_cnt;
    for (int i = 0; i < 255; i++) begin
      hold_value(4'h0, 7);
      hold_value(4'hF, 7);
    end
    get_snapshot(edges);
    total++;
    if (out_wraps !== 8'hFF || out_count !== 4'hF || pulse_cnt - p0 != 255) begin
      bad++;
      $display("FAIL wraps_255: got wraps=%h count=%h pulses=%0d want FF/F/255",
               out_wraps, out_count, pulse_cnt - p0);
    end
    release_snapshot();
    hold_value(4'h0, 7);
    hold_value(4'hF, 7);
    get_snapshot(edges);
    total++;
    if (out_wraps !== 8'h00 || pulse_cnt - p0 != 256) begin
      bad++;
      $display("FAIL wraps_roll: got wraps=%h pulses=%0d want 00/256", out_wraps, pulse_cnt - p0);
    end
    release_snapshot();
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    pulse_cnt  = 0;
    rst        = 1'b1;
    cnt_in     = 4'h0;
    sample_req = 1'b0;
    out_ready  = 1'b0;
    test_reset();
    test_basic_snapshot();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_glitch();
    test_reset_hold_rollover();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
